piso_serializer: RTL

Parallel-in, serial-out transmitter. It is the sending end for the team's serial-in bidirectional shift register.
- Accepts a WIDTH-bit word via a valid/ready handshake.
- Shifts the word out one bit per enabled clock, MSB-first or LSB-first, chosen per word by mode.
- Signals completion with a one-cycle done pulse.
- Sits between a parallel data source and a serial link feeding the receiver shift register.

---
 rtl/piso_serializer_pkg.sv | 14 +
 rtl/piso_serializer_if.sv | 26 ++
 rtl/piso_bit_counter.sv | 29 ++
 rtl/piso_serializer.sv | 108 ++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the PISO serializer.
// Holds the FSM state encoding and the bit-order mode values.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  localparam logic MODE_MSB_FIRST = 1'b0;
  localparam logic MODE_LSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel word handshake between a data source and the serializer.
// The source drives valid/data/mode; the serializer returns ready.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             mode;

  modport master (
    output in_valid,
    output in_data,
    output mode,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  mode,
    output in_ready
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter for the serializer.
// Flags the terminal count when the last data bit is on the line.
module piso_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter, MSB- or LSB-first per word.
// Define SERIAL_PARITY_EN to append an even-parity bit to each frame.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  piso_serializer_if.slave bus,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic             mode_q;
  logic             last;
  logic             accept;
`ifdef SERIAL_PARITY_EN
  logic             par_q;
`endif

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid & bus.in_ready;
  assign sout_valid   = (state != IDLE);
  assign busy         = (state != IDLE);

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .inc  ((state == SHIFT) & en),
    .last (last)
  );

  always_comb begin
    sout = 1'b0;
    unique case (1'b1)
      (state == SHIFT):
        sout = (mode_q == MODE_LSB_FIRST)
             ? sr[0] : sr[WIDTH-1];
`ifdef SERIAL_PARITY_EN
      (state == PARITY):
        sout = par_q;
`endif
      default:
        sout = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      sr     <= '0;
      mode_q <= MODE_MSB_FIRST;
      done   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sr     <= bus.in_data;
            mode_q <= bus.mode;
            state  <= SHIFT;
`ifdef SERIAL_PARITY_EN
            par_q  <= ^bus.in_data;
`endif
          end
        end
        SHIFT: begin
          if (en) begin
            sr <= (mode_q == MODE_LSB_FIRST)
                ? (sr >> 1) : (sr << 1);
            if (last) begin
`ifdef SERIAL_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        end
        PARITY: begin
`ifdef SERIAL_PARITY_EN
          if (en) begin
            state <= IDLE;
            done  <= 1'b1;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
